// File: rtl/axi_rd_rr_arbiter.sv
// N-master to 1-slave AXI4 read arbiter: round-robin AR grant, registered slave AR,
// R channel locked to the granted master until RLAST. Optional RID check: AXI_ARB_RID_CHECK_EN.
module axi_rd_rr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [NUM_M-1:0]        m_arvalid_i,
    output logic [NUM_M-1:0]        m_arready_o,
    input  logic [NUM_M*ADDR_W-1:0] m_araddr_i,
    input  logic [NUM_M*8-1:0]      m_arlen_i,
    output logic [NUM_M-1:0]        m_rvalid_o,
    input  logic [NUM_M-1:0]        m_rready_i,
    output logic [DATA_W-1:0]       m_rdata_o,
    output logic [1:0]              m_rresp_o,
    output logic                    m_rlast_o,
    output logic                    s_arvalid_o,
    input  logic                    s_arready_i,
    output logic [ADDR_W-1:0]       s_araddr_o,
    output logic [7:0]              s_arlen_o,
    output logic [ID_W-1:0]         s_arid_o,
    input  logic                    s_rvalid_i,
    output logic                    s_rready_o,
    input  logic [DATA_W-1:0]       s_rdata_i,
    input  logic [1:0]              s_rresp_i,
    input  logic                    s_rlast_i,
    input  logic [ID_W-1:0]         s_rid_i,
    output logic                    busy_o,
    output logic                    err_rid_o
);

    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R} state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic                err_q, err_d;

    logic [GW-1:0]       sel;
    logic                any_req;
    logic                r_hs;
    logic                rid_bad;

    // Round-robin pick: scan downward so the nearest requester after last_grant wins.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        for (int k = NUM_M; k >= 1; k--) begin
            if (m_arvalid_i[(int'(last_grant_q) + k) % NUM_M]) begin
                sel     = GW'((int'(last_grant_q) + k) % NUM_M);
                any_req = 1'b1;
            end
        end
    end

`ifdef AXI_ARB_RID_CHECK_EN
    assign rid_bad = (s_rid_i != ID_W'(grant_q));
`else
    logic unused_rid;
    assign unused_rid = ^s_rid_i;
    assign rid_bad    = 1'b0;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GW'(NUM_M - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        err_d        = err_q;
        m_arready_o  = '0;
        m_rvalid_o   = '0;
        m_rdata_o    = '0;
        m_rresp_o    = '0;
        m_rlast_o    = 1'b0;
        s_arvalid_o  = 1'b0;
        s_rready_o   = 1'b0;
        r_hs         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    // Gated by reset so outputs read 0 while reset is asserted.
                    m_arready_o[sel] = ~reset_i;
                    grant_d          = sel;
                    addr_d           = m_araddr_i[int'(sel)*ADDR_W +: ADDR_W];
                    len_d            = m_arlen_i[int'(sel)*8 +: 8];
                    state_d          = ST_AR;
                end
            end
            ST_AR: begin
                s_arvalid_o = 1'b1;
                if (s_arready_i) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                m_rvalid_o[grant_q] = s_rvalid_i;
                s_rready_o          = m_rready_i[grant_q];
                m_rdata_o           = s_rdata_i;
                m_rresp_o           = s_rresp_i;
                m_rlast_o           = s_rlast_i;
                r_hs                = s_rvalid_i & m_rready_i[grant_q];
                if (r_hs && rid_bad) begin
                    m_rresp_o = 2'b10;
                    err_d     = 1'b1;
                end
                if (r_hs && s_rlast_i) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s_araddr_o = addr_q;
    assign s_arlen_o  = len_q;
    assign s_arid_o   = ID_W'(grant_q);
    assign busy_o     = (state_q != ST_IDLE);

`ifdef AXI_ARB_RID_CHECK_EN
    assign err_rid_o = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
    assign err_rid_o  = 1'b0;
`endif

endmodule

// File: doc/axi_rd_rr_arbiter.md
Name: axi_rd_rr_arbiter

Overview:
- Parametrised N-master to 1-slave AXI4 read-channel arbiter (AR and R channels), placed between the fetch/load-store masters and the shared memory port.
- Grants are round-robin.
- The granted request is registered and presented on the slave AR channel with a master-derived ARID.
- The R channel is then locked to the granted master until the RLAST handshake.
- One transaction is outstanding at a time.

Parameters:
- NUM_M, 2, number of masters (index 0 = IFU, 1 = LSU); range 2..8.
- ADDR_W, 32, address width.
- DATA_W, 64, read data width.
- ID_W, 4, AXI ID width; must be >= clog2(NUM_M).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_arvalid  in  NUM_M  per-master read request
- m_arready  out  NUM_M  per-master request accepted
- m_araddr  in  NUM_M*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W]
- m_arlen  in  NUM_M*8  packed burst lengths
- m_rvalid  out  NUM_M  per-master read beat valid
- m_rready  in  NUM_M  per-master read beat ready
- m_rdata  out  DATA_W  broadcast read data
- m_rresp  out  2  broadcast response
- m_rlast  out  1  broadcast last beat
- s_arvalid  out  1  slave AR valid
- s_arready  in  1  slave AR ready
- s_araddr  out  ADDR_W  slave address
- s_arlen  out  8  slave burst length
- s_arid  out  ID_W  granted master index, zero-extended
- s_rvalid  in  1  slave R valid
- s_rready  out  1  slave R ready
- s_rdata  in  DATA_W  slave data
- s_rresp  in  2  slave response
- s_rlast  in  1  slave last
- s_rid  in  ID_W  slave response ID
- busy  out  1  high in AR or R state
- err_rid  out  1  sticky RID-mismatch flag (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high, any state):
  - state = IDLE; last_grant = NUM_M-1, so master 0 wins first.
  - All latched address/len/grant registers cleared.
  - All outputs 0.
  - An in-flight burst is abandoned; no beats are forwarded after reset.
- State IDLE:
  - sel = first i with m_arvalid[i]=1, searching from (last_grant+1) mod NUM_M upward with wrap.
  - If any m_arvalid: m_arready[sel]=1 combinationally (other bits 0); latch grant=sel, m_araddr[sel], m_arlen[sel]; next state AR.
  - No request: stay in IDLE, m_arready=0.
- State AR:
  - s_arvalid=1; s_araddr/s_arlen/s_arid driven from registers, stable until handshake.
  - s_arvalid rises exactly 1 cycle after the master handshake.
  - On s_arready=1: next state R. Otherwise hold.
  - m_arready=0 for all masters.
- State R:
  - m_rvalid[grant]=s_rvalid; other m_rvalid bits 0.
  - s_rready=m_rready[grant].
  - m_rdata/m_rresp/m_rlast = s_rdata/s_rresp/s_rlast, passed through combinationally.
  - Each handshake with s_rlast=1: last_grant=grant; next state IDLE.
  - Beats without rlast keep the state in R.
- Request accepted on the same edge the burst completes:
  - Not possible: new requests are sampled only in IDLE.
  - Minimum turnaround: 1 idle cycle between RLAST and the next m_arready.
- Fairness:
  - Continuous requests from all masters are granted in order 0,1,..,NUM_M-1,0,…
  - A lone requester is granted on every transaction.
- No combinational path from s_arready to m_arready.
- s_rvalid outside state R is ignored and s_rready=0.

Optional Feature:
- Macro: AXI_ARB_RID_CHECK_EN.
- Defined:
  - In R, a beat handshake with s_rid != grant forwards m_rresp=2'b10 (SLVERR) instead of s_rresp.
  - err_rid is set on the following clock and stays 1 until reset.
- Undefined:
  - s_rid is ignored.
  - m_rresp=s_rresp.
  - err_rid is tied 0.

Test Plan:
- Reset, then m_arvalid=2'b11, araddr0=0x8000_0000, araddr1=0x8000_1000 -> master 0 granted first (s_arid=0, s_araddr=0x8000_0000); after its RLAST, master 1 granted (s_arid=1, s_araddr=0x8000_1000).
- Master 1 requests alone three times with 1-beat bursts -> three grants to master 1; each s_arvalid appears 1 cycle after m_arready[1].
- arlen=3, slave toggles s_rvalid and master 0 deasserts m_rready every other cycle -> exactly 4 beats reach master 0 with data intact; m_rvalid[1] stays 0; return to IDLE only after the RLAST handshake.
- s_arready held 0 for 5 cycles -> s_araddr/s_arid stable and s_arvalid=1 throughout; a new m_arvalid from the other master gets no m_arready.
- Assert reset mid-burst (state R, beat 2 of 4) -> all outputs 0 immediately; after release, the next grant goes to master 0.
- With AXI_ARB_RID_CHECK_EN: grant=0, slave returns s_rid=1, s_rresp=0 -> m_rresp=2'b10, err_rid=1 and stays 1; without the macro -> m_rresp=0, err_rid=0.
